// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store, LSU-priority with IF starvation guard.
// Optional MEM_ARB_MISALIGN_CHK_EN: misaligned requests get an immediate error response with no memory access.
module mem_port_arbiter #(
  parameter int N          = 13,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [N-1:0]  if_req_addr,
  output logic          if_rsp_valid,
  output logic [31:0]   if_rsp_data,
`ifdef MEM_ARB_MISALIGN_CHK_EN
  output logic          if_rsp_err,
  output logic          ls_rsp_err,
`endif
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic          ls_req_we,
  input  logic [1:0]    ls_req_size,
  input  logic [N-1:0]  ls_req_addr,
  input  logic [63:0]   ls_req_wdata,
  output logic          ls_rsp_valid,
  output logic [63:0]   ls_rsp_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [N-1:0]  mem_addr,
  output logic [63:0]   mem_wdata,
  output logic [7:0]    mem_wstrb,
  input  logic [63:0]   mem_rdata,
  input  logic          mem_rvalid
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [1:0]    state_q, state_d;
  logic          own_ls_q, own_ls_d;
  logic [N-1:0]  addr_q, addr_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          idle, force_if, grant_ls, grant_if, issue, resp;

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [7:0] size_strb(input logic [1:0] s);
    case (s)
      2'd0:    size_strb = 8'h01;
      2'd1:    size_strb = 8'h03;
      2'd2:    size_strb = 8'h0F;
      default: size_strb = 8'hFF;
    endcase
  endfunction

  assign idle     = (state_q == S_IDLE);
  assign issue    = (state_q == S_ISSUE);
  assign resp     = (state_q == S_RESP);
  assign force_if = (starve_q == SW'(MAX_STARVE)) && if_req_valid;
  assign grant_ls = idle && ls_req_valid && !force_if;
  assign grant_if = idle && if_req_valid && !grant_ls;

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

`ifdef MEM_ARB_MISALIGN_CHK_EN
  logic err_q, err_d, mis;
  logic [2:0] ls_low;
  always_comb begin
    case (ls_req_size)
      2'd0:    ls_low = 3'b000;
      2'd1:    ls_low = 3'b001;
      2'd2:    ls_low = 3'b011;
      default: ls_low = 3'b111;
    endcase
    mis = grant_ls ? |(ls_req_addr[2:0] & ls_low) : |if_req_addr[1:0];
  end
`endif

  always_comb begin
    state_d  = state_q;
    own_ls_d = own_ls_q;
    addr_d   = addr_q;
    we_d     = we_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
`ifdef MEM_ARB_MISALIGN_CHK_EN
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_ls || grant_if) begin
          own_ls_d = grant_ls;
          addr_d   = grant_ls ? ls_req_addr : if_req_addr;
          we_d     = grant_ls && ls_req_we;
          size_d   = grant_ls ? ls_req_size : 2'd2;
          wdata_d  = grant_ls ? ls_req_wdata : 64'd0;
          rdata_d  = 64'd0;
          state_d  = S_ISSUE;
`ifdef MEM_ARB_MISALIGN_CHK_EN
          err_d    = mis;
          if (mis) state_d = S_RESP;
`endif
        end
        // IF losing to LSU ages the guard; any IF win or IF idle resets it
        if (!if_req_valid || grant_if)
          starve_d = '0;
        else if (grant_ls && starve_q != SW'(MAX_STARVE))
          starve_d = starve_q + SW'(1);
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = we_q ? 64'd0 : (mem_rdata & size_mask(size_q));
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      own_ls_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      wdata_q  <= 64'd0;
      rdata_q  <= 64'd0;
      starve_q <= '0;
`ifdef MEM_ARB_MISALIGN_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      own_ls_q <= own_ls_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
`ifdef MEM_ARB_MISALIGN_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign mem_req      = issue;
  assign mem_we       = issue && we_q;
  assign mem_addr     = issue ? addr_q : '0;
  assign mem_wdata    = issue ? wdata_q : 64'd0;
  assign mem_wstrb    = (issue && we_q) ? size_strb(size_q) : 8'h00;
  assign if_rsp_valid = resp && !own_ls_q;
  assign ls_rsp_valid = resp && own_ls_q;
  assign if_rsp_data  = if_rsp_valid ? rdata_q[31:0] : 32'd0;
  assign ls_rsp_data  = ls_rsp_valid ? rdata_q : 64'd0;
`ifdef MEM_ARB_MISALIGN_CHK_EN
  assign if_rsp_err   = if_rsp_valid && err_q;
  assign ls_rsp_err   = ls_rsp_valid && err_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a byte-array memory
// and a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int N  = 13;
  localparam int MS = 4;

  logic clk, rst_n;
  logic if_req_valid, if_req_ready, if_rsp_valid;
  logic [N-1:0] if_req_addr;
  logic [31:0] if_rsp_data;
  logic ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [1:0] ls_req_size;
  logic [N-1:0] ls_req_addr;
  logic [63:0] ls_req_wdata, ls_rsp_data;
  logic mem_req, mem_we, mem_rvalid;
  logic [N-1:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0] mem_wstrb;
`ifdef MEM_ARB_MISALIGN_CHK_EN
  logic if_rsp_err, ls_rsp_err;
`endif

  mem_port_arbiter #(.N(N), .MAX_STARVE(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
`ifdef MEM_ARB_MISALIGN_CHK_EN
    .if_rsp_err(if_rsp_err), .ls_rsp_err(ls_rsp_err),
`endif
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_size(ls_req_size), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int losses = 0;
  byte unsigned mem [0:8191];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input int a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[(a + i) % 8192];
    return r;
  endfunction

  function automatic logic [63:0] lo_mask(input int sz);
    return (sz == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << sz)) - 64'd1);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_ready"}, if_req_ready, 0);
    chk({tag, "_ls_ready"}, ls_req_ready, 0);
    chk({tag, "_if_rsp"}, if_rsp_valid, 0);
    chk({tag, "_ls_rsp"}, ls_rsp_valid, 0);
  endtask

  // Caller sets request inputs just after a falling edge; this runs one whole transaction.
  task automatic serve(input int lat, input bit force_en, input logic [63:0] force_val, output bit got_ls);
    bit exp_if, exp_ls, found, we, mis;
    int a, sz;
    logic [63:0] wd, rd, exp_data;
    found = 0; exp_if = 0; exp_ls = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_if = if_req_valid && (losses == MS || !ls_req_valid);
      exp_ls = ls_req_valid && !exp_if;
      chk("if_ready", if_req_ready, exp_if);
      chk("ls_ready", ls_req_ready, exp_ls);
      found = exp_if || exp_ls;
      if (!found && !if_req_valid) losses = 0;
    end
    got_ls = exp_ls;
    if (!found) begin
      chk("handshake_timeout", 1, 0);
      return;
    end
    a  = exp_ls ? int'(ls_req_addr) : int'(if_req_addr);
    we = exp_ls && ls_req_we;
    sz = exp_ls ? int'(ls_req_size) : 2;
    wd = ls_req_wdata;
    if (!exp_ls) losses = 0;
    else if (if_req_valid) losses = (losses < MS) ? losses + 1 : MS;
    else losses = 0;
`ifdef MEM_ARB_MISALIGN_CHK_EN
    mis = (a % (1 << sz)) != 0;
`else
    mis = 0;
`endif
    @(negedge clk);
    if (exp_ls) ls_req_valid = 0; else if_req_valid = 0;
    #1;
    chk("busy_if_ready", if_req_ready, 0);
    chk("busy_ls_ready", ls_req_ready, 0);
    if (mis) begin
`ifdef MEM_ARB_MISALIGN_CHK_EN
      chk("mis_no_mem_req", mem_req, 0);
      chk("mis_if_rsp", if_rsp_valid, !exp_ls);
      chk("mis_ls_rsp", ls_rsp_valid, exp_ls);
      chk("mis_err", exp_ls ? ls_rsp_err : if_rsp_err, 1);
      chk("mis_data", exp_ls ? ls_rsp_data : 64'(if_rsp_data), 0);
`endif
      return;
    end
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, a);
    chk("mem_we", mem_we, we);
    chk("mem_wstrb", mem_wstrb, we ? ((64'd1 << (1 << sz)) - 64'd1) : 64'd0);
    if (we) chk("mem_wdata", mem_wdata, wd);
    rd = force_en ? force_val : mem_rd(a);
    if (we) for (int i = 0; i < (1 << sz); i++) mem[(a + i) % 8192] = wd[8*i +: 8];
    exp_data = we ? 64'd0 : (rd & lo_mask(sz));
    for (int j = 1; j < lat; j++) begin
      @(negedge clk); #1;
      chk("wait_mem_req", mem_req, 0);
      chk_quiet("wait");
    end
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = rd;
    #1;
    chk_quiet("rvalid");
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = {$urandom, $urandom};
    #1;
    chk("rsp_if_valid", if_rsp_valid, !exp_ls);
    chk("rsp_ls_valid", ls_rsp_valid, exp_ls);
    chk("rsp_data", exp_ls ? ls_rsp_data : 64'(if_rsp_data), exp_data);
`ifdef MEM_ARB_MISALIGN_CHK_EN
    chk("rsp_err", exp_ls ? ls_rsp_err : if_rsp_err, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int sz;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    rst_n = 0; if_req_valid = 0; if_req_addr = 0;
    ls_req_valid = 0; ls_req_we = 0; ls_req_size = 0; ls_req_addr = 0; ls_req_wdata = 0;
    mem_rdata = 0; mem_rvalid = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_ls_data", ls_rsp_data, 0);
    chk_quiet("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // IF fetch, latency 1
    @(negedge clk);
    if_req_valid = 1; if_req_addr = 13'h010;
    serve(1, 1, 64'h1122_3344_5566_7788, g);
    chk("fetch_grant_is_if", g, 0);
    chk("fetch_data_const", if_rsp_data, 32'h5566_7788);

    // Starvation: LSU wins four times, IF wins the fifth
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_req_valid = 1; if_req_addr = 13'h020;
      ls_req_valid = 1; ls_req_we = 0; ls_req_size = 2'd3; ls_req_addr = 13'h100;
      serve(1, 0, 0, g);
      chk("starve_grant", g, (i < 4) ? 1 : 0);
    end
    @(negedge clk);
    if_req_valid = 0; ls_req_valid = 0;

    // Store half
    @(negedge clk);
    ls_req_valid = 1; ls_req_we = 1; ls_req_size = 2'd1; ls_req_addr = 13'h1002; ls_req_wdata = 64'hABCD;
    serve(2, 0, 0, g);
    chk("store_data_zero", ls_rsp_data, 0);

    // Byte load, latency 3, sign bit set in memory
    @(negedge clk);
    ls_req_valid = 1; ls_req_we = 0; ls_req_size = 2'd0; ls_req_addr = 13'h0005;
    serve(3, 1, 64'hFFFF_FFFF_FFFF_FF80, g);
    chk("byte_load_const", ls_rsp_data, 64'h80);

    // Reset during WAIT, then a late rvalid
    @(negedge clk);
    ls_req_valid = 1; ls_req_we = 0; ls_req_size = 2'd2; ls_req_addr = 13'h0200;
    #1 chk("rw_ready", ls_req_ready, 1);
    @(negedge clk);
    ls_req_valid = 0;
    #1 chk("rw_issue", mem_req, 1);
    @(negedge clk); #1;
    chk("rw_wait", mem_req, 0);
    rst_n = 0;
    #1;
    chk_quiet("rw_in_reset");
    @(negedge clk);
    rst_n = 1; mem_rvalid = 1; mem_rdata = 64'h1234;
    #1 chk_quiet("rw_late_rvalid");
    @(negedge clk);
    mem_rvalid = 0;
    #1 chk_quiet("rw_after");
    losses = 0;
    @(negedge clk);
    if_req_valid = 1; if_req_addr = 13'h0040;
    serve(1, 0, 0, g);
    chk("rw_new_grant_if", g, 0);

    // Misaligned dword load (error response when the check is built in)
    @(negedge clk);
    ls_req_valid = 1; ls_req_we = 0; ls_req_size = 2'd3; ls_req_addr = 13'h1004;
    serve(1, 0, 0, g);

    // Random traffic; a held request keeps its payload
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!if_req_valid && $urandom_range(0, 1) == 1) begin
        if_req_valid = 1;
        if_req_addr = N'($urandom_range(0, 8191));
        if ($urandom_range(0, 3) != 0) if_req_addr[1:0] = 2'b00;
      end
      if (!ls_req_valid && ($urandom_range(0, 2) != 0 || !if_req_valid)) begin
        ls_req_valid = 1;
        ls_req_we = 1'($urandom_range(0, 1));
        sz = $urandom_range(0, 3);
        ls_req_size = 2'(sz);
        ls_req_addr = N'($urandom_range(0, 8191));
        if ($urandom_range(0, 3) != 0) ls_req_addr = ls_req_addr & ~N'((1 << sz) - 1);
        ls_req_wdata = {$urandom, $urandom};
      end
      serve($urandom_range(1, 4), 0, 0, g);
    end
    @(negedge clk);
    if_req_valid = 0; ls_req_valid = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
